// File: rtl/servo_sequencer_if.sv
// Handshake and PWM bundle between flag_handling and the servo sequencer.
//   master : flag_handling side - drives start/servo_state, observes status and PWM
//   slave  : servo_sequencer side - consumes requests, drives busy/servo_done/PWM
// Signals:
//   start        request a motion (sampled only while the sequencer is idle)
//   servo_state  motion select, sampled with start: 0 = pickup, 1 = dropoff
//   busy         motion in progress
//   servo_done   one-cycle completion pulse
//   pwm_arm      arm servo PWM
//   pwm_claw     claw servo PWM
interface servo_sequencer_if;
  logic start;
  logic servo_state;
  logic busy;
  logic servo_done;
  logic pwm_arm;
  logic pwm_claw;

  modport master (
    output start, servo_state,
    input  busy, servo_done, pwm_arm, pwm_claw
  );

  modport slave (
    input  start, servo_state,
    output busy, servo_done, pwm_arm, pwm_claw
  );
endinterface

// File: rtl/servo_sequencer.sv
// Arm/claw servo sequencer for the rover.
// Runs a four-step pickup or dropoff motion on request and generates both
// servo PWM signals. Pulse widths change only on PWM frame boundaries, so a
// servo never sees a runt or stretched pulse.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  servo_sequencer_if.slave: start, servo_state in; busy, servo_done,
//        pwm_arm, pwm_claw out (all outputs registered)
module servo_sequencer #(
  parameter int unsigned PERIOD_CYC  = 1000000,
  parameter int unsigned HOLD_FRAMES = 25,
  parameter int unsigned ARM_UP      = 50000,
  parameter int unsigned ARM_DOWN    = 100000,
  parameter int unsigned CLAW_OPEN   = 50000,
  parameter int unsigned CLAW_CLOSED = 100000
) (
  input  logic              clk,
  input  logic              rst,
  servo_sequencer_if.slave  bus
);

  localparam int unsigned FW = $clog2(PERIOD_CYC);
  localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] S0    = 3'd2;
  localparam logic [2:0] S1    = 3'd3;
  localparam logic [2:0] S2    = 3'd4;
  localparam logic [2:0] S3    = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] w_arm;
  logic [FW-1:0] w_claw;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;
  logic [2:0]    state;
  logic [2:0]    next_state;
  logic          op;
  logic          wrap;
  logic          hold_last;
  logic          arm_down_cmd;
  logic          claw_open_cmd;
  logic [FW-1:0] arm_w_cmd;
  logic [FW-1:0] claw_w_cmd;

  assign wrap      = (frame_cnt == FW'(PERIOD_CYC - 1));
  assign hold_last = (hold_cnt == HW'(HOLD_FRAMES - 1));

  always_comb begin
    next_state = state;
    hold_next  = hold_cnt;
    case (state)
      IDLE: begin
        if (bus.start) next_state = ARMED;
      end
      ARMED: begin
        if (wrap) begin
          next_state = S0;
          hold_next  = '0;
        end
      end
      S0, S1, S2, S3: begin
        if (wrap) begin
          if (hold_last) begin
            hold_next  = '0;
            next_state = (state == S3) ? DONE : state + 3'd1;
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
      end
      // DONE carries the servo_done cycle; start is not accepted until IDLE.
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Position is decoded from the state being entered, so the widths latched
  // on a wrap already belong to the step that the following frame starts.
  // Both motions end UP/CLOSED, which is also the idle/reset position.
  always_comb begin
    arm_down_cmd  = 1'b0;
    claw_open_cmd = 1'b0;
    case (next_state)
      S0: begin
        arm_down_cmd  = op;
        claw_open_cmd = !op;
      end
      S1: begin
        arm_down_cmd  = 1'b1;
        claw_open_cmd = 1'b1;
      end
      S2: begin
        arm_down_cmd  = !op;
        claw_open_cmd = op;
      end
      default: begin
        arm_down_cmd  = 1'b0;
        claw_open_cmd = 1'b0;
      end
    endcase
  end

  assign arm_w_cmd  = arm_down_cmd  ? FW'(ARM_DOWN)  : FW'(ARM_UP);
  assign claw_w_cmd = claw_open_cmd ? FW'(CLAW_OPEN) : FW'(CLAW_CLOSED);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt      <= '0;
      hold_cnt       <= '0;
      state          <= IDLE;
      op             <= 1'b0;
      w_arm          <= FW'(ARM_UP);
      w_claw         <= FW'(CLAW_CLOSED);
      bus.busy       <= 1'b0;
      bus.servo_done <= 1'b0;
      bus.pwm_arm    <= 1'b0;
      bus.pwm_claw   <= 1'b0;
    end else begin
      frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
      state     <= next_state;
      hold_cnt  <= hold_next;
      if (state == IDLE && bus.start) op <= bus.servo_state;
      if (wrap) begin
        w_arm  <= arm_w_cmd;
        w_claw <= claw_w_cmd;
      end
      bus.pwm_arm    <= (frame_cnt < w_arm);
      bus.pwm_claw   <= (frame_cnt < w_claw);
      bus.busy       <= (next_state == ARMED) || (next_state == S0) ||
                        (next_state == S1)    || (next_state == S2) ||
                        (next_state == S3);
      bus.servo_done <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_servo_sequencer.sv
// Self-checking bench for servo_sequencer with a 10-cycle PWM frame and
// two-frame motion steps.
module tb_servo_sequencer;
  localparam int P = 10;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  servo_sequencer_if bus ();

  servo_sequencer #(
    .PERIOD_CYC (10),
    .HOLD_FRAMES(2),
    .ARM_UP     (2),
    .ARM_DOWN   (4),
    .CLAW_OPEN  (3),
    .CLAW_CLOSED(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference frame counter, same phase as the DUT's.
  int   fc = 0;
  logic rst_edge = 1'b0;
  always @(posedge clk) begin
    rst_edge <= rst;
    fc       <= rst ? 0 : ((fc == P - 1) ? 0 : fc + 1);
  end

  // Per-frame high-time history and per-pulse legality check.
  int arm_hist  [1024];
  int claw_hist [1024];
  int frame_idx = 0;
  int acc_a = 0, acc_c = 0, run_a = 0, run_c = 0;

  always @(negedge clk) begin
    if (fc == 0) begin
      acc_a = int'(bus.pwm_arm);
      acc_c = int'(bus.pwm_claw);
    end else begin
      acc_a += int'(bus.pwm_arm);
      acc_c += int'(bus.pwm_claw);
    end
    if (fc == P - 1) begin
      arm_hist[frame_idx % 1024]  = acc_a;
      claw_hist[frame_idx % 1024] = acc_c;
      frame_idx++;
    end
    if (rst_edge) begin
      run_a = 0;
      run_c = 0;
    end else begin
      if (bus.pwm_arm) run_a++;
      else if (run_a != 0) begin
        check("arm_pulse_legal", int'(run_a == 2 || run_a == 4), 1);
        run_a = 0;
      end
      if (bus.pwm_claw) run_c++;
      else if (run_c != 0) begin
        check("claw_pulse_legal", int'(run_c == 3 || run_c == 6), 1);
        run_c = 0;
      end
    end
  end

  typedef struct {
    logic op;
    int   step;
    int   arm_w;
    int   claw_w;
  } step_vec_t;

  step_vec_t tbl [8];

  task automatic do_start(input logic op, output int s0_frame);
    int guard = 0;
    while (fc != 3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("busy_before_start", int'(bus.busy), 0);
    bus.start       = 1'b1;
    bus.servo_state = op;
    @(negedge clk);
    bus.start       = 1'b0;
    bus.servo_state = ~op;
    check("busy_rise", int'(bus.busy), 1);
    guard = 0;
    while (fc != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    s0_frame = frame_idx;
  endtask

  // Called on the S0 entry cycle; restart_at is S0-relative (-1 for none).
  task automatic finish_motion(input int restart_at, input logic start_at_done);
    int done_cyc = -1;
    int busy_bad = 0;
    int extra    = 0;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      if (bus.servo_done) done_cyc = c;
      else if (!bus.busy) busy_bad++;
      bus.start       = (c == restart_at);
      bus.servo_state = 1'b1;
      if (done_cyc < 0) @(negedge clk);
    end
    check("done_latency", done_cyc, 80);
    check("busy_during_motion", busy_bad, 0);
    check("busy_low_at_done", int'(bus.busy), 0);
    bus.start = start_at_done;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", int'(bus.servo_done), 0);
    repeat (30) begin
      if (bus.busy || bus.servo_done) extra++;
      @(negedge clk);
    end
    check("no_extra_activity", extra, 0);
  endtask

  task automatic check_frames(input logic op, input int s0f);
    check("armed_frame_arm",  arm_hist[(s0f - 1) % 1024], 2);
    check("armed_frame_claw", claw_hist[(s0f - 1) % 1024], 6);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].op == op) begin
        for (int f = 0; f < H; f++) begin
          check($sformatf("op%0d_s%0d_f%0d_arm", op, tbl[i].step, f),
                arm_hist[(s0f + H * tbl[i].step + f) % 1024], tbl[i].arm_w);
          check($sformatf("op%0d_s%0d_f%0d_claw", op, tbl[i].step, f),
                claw_hist[(s0f + H * tbl[i].step + f) % 1024], tbl[i].claw_w);
        end
      end
    end
    check("after_frame_arm",  arm_hist[(s0f + 4 * H) % 1024], 2);
    check("after_frame_claw", claw_hist[(s0f + 4 * H) % 1024], 6);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0f;
    int bad;
    int f0;

    tbl[0] = '{1'b0, 0, 2, 3};
    tbl[1] = '{1'b0, 1, 4, 3};
    tbl[2] = '{1'b0, 2, 4, 6};
    tbl[3] = '{1'b0, 3, 2, 6};
    tbl[4] = '{1'b1, 0, 4, 6};
    tbl[5] = '{1'b1, 1, 4, 3};
    tbl[6] = '{1'b1, 2, 2, 3};
    tbl[7] = '{1'b1, 3, 2, 6};

    bus.start       = 1'b0;
    bus.servo_state = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.servo_done), 0);
    check("rst_pwm_arm", int'(bus.pwm_arm), 0);
    check("rst_pwm_claw", int'(bus.pwm_claw), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle: UP/CLOSED every frame, no status activity
    f0  = frame_idx;
    bad = 0;
    repeat (50) begin
      if (bus.busy || bus.servo_done) bad++;
      @(negedge clk);
    end
    check("idle_busy_done", bad, 0);
    for (int i = 0; i < 5; i++) begin
      check("idle_arm", arm_hist[(f0 + i) % 1024], 2);
      check("idle_claw", claw_hist[(f0 + i) % 1024], 6);
    end

    // Pickup
    do_start(1'b0, s0f);
    finish_motion(-1, 1'b0);
    check_frames(1'b0, s0f);

    // Dropoff
    do_start(1'b1, s0f);
    finish_motion(-1, 1'b0);
    check_frames(1'b1, s0f);

    // Pickup with a second start 15 cycles after acceptance and a start
    // coinciding with the servo_done pulse; both must be ignored.
    do_start(1'b0, s0f);
    finish_motion(9, 1'b1);
    check_frames(1'b0, s0f);

    // Reset during S2 of a pickup
    do_start(1'b0, s0f);
    repeat (45) @(negedge clk);
    check("busy_in_s2", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.servo_done), 0);
    check("midrst_pwm_arm", int'(bus.pwm_arm), 0);
    check("midrst_pwm_claw", int'(bus.pwm_claw), 0);
    f0  = frame_idx;
    bad = 0;
    repeat (100) begin
      if (bus.busy || bus.servo_done) bad++;
      @(negedge clk);
    end
    check("post_rst_quiet", bad, 0);
    for (int i = 0; i < 10; i++) begin
      check("post_rst_arm", arm_hist[(f0 + i) % 1024], 2);
      check("post_rst_claw", claw_hist[(f0 + i) % 1024], 6);
    end

    // Normal pickup after the mid-motion reset
    do_start(1'b0, s0f);
    finish_motion(-1, 1'b0);
    check_frames(1'b0, s0f);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
